// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the writeback path: default widths and the
// writeback arbiter priority state.
package cpu_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef enum logic [0:0] {
    PRI0 = 1'b0,
    PRI1 = 1'b1
  } arb_state_t;
endpackage

// File: rtl/wb_scoreboard.sv
// Per-register busy bits for pending long-latency results: reservation on
// issue, release on the long-latency writeback, and the decode-side lookups.
module wb_scoreboard #(
  parameter int ADDR_W = cpu_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_iss_valid,
  input  logic [ADDR_W-1:0] i_iss_rd,
  output logic              o_iss_ready,
  input  logic              i_clr_en,
  input  logic [ADDR_W-1:0] i_clr_wn,
  input  logic [ADDR_W-1:0] i_rs,
  input  logic [ADDR_W-1:0] i_rt,
  input  logic [ADDR_W-1:0] i_chk_wn,
  output logic              o_hazard,
  output logic              o_chk_busy
);
  import cpu_pkg::*;

  localparam int NREG = 2 ** ADDR_W;

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_nxt;
  logic            w_set_en;
  logic            w_clr_en;

  // r0 is hardwired zero, so it can never be pending.
  function automatic logic f_busy(input logic [NREG-1:0] vec, input logic [ADDR_W-1:0] idx);
    return (idx != {ADDR_W{1'b0}}) & vec[idx];
  endfunction

  assign o_iss_ready = !f_busy(r_busy, i_iss_rd);
  assign w_set_en    = i_iss_valid & o_iss_ready & (i_iss_rd != {ADDR_W{1'b0}});
  assign w_clr_en    = i_clr_en & (i_clr_wn != {ADDR_W{1'b0}});
  assign o_hazard    = f_busy(r_busy, i_rs) | f_busy(r_busy, i_rt);
  assign o_chk_busy  = f_busy(r_busy, i_chk_wn);

  // Next busy vector; a new reservation beats a release of the same register.
  always_comb begin
    w_busy_nxt = {NREG{1'b0}};
    for (int i = 1; i < NREG; i++) begin
      w_busy_nxt[i] = (w_set_en && (i_iss_rd == ADDR_W'(i))) ? 1'b1 :
                      (w_clr_en && (i_clr_wn == ADDR_W'(i))) ? 1'b0 : r_busy[i];
    end
  end

  // Busy vector register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= {NREG{1'b0}};
    end else begin
      r_busy <= w_busy_nxt;
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between pipeline writeback
// (p0) and starvation-bounded long-latency writeback (p1).
module regfile_wb_arbiter #(
  parameter int DATA_W       = cpu_pkg::DATA_W,
  parameter int ADDR_W       = cpu_pkg::ADDR_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_valid,
  output logic              p0_ready,
  input  logic [ADDR_W-1:0] p0_wn,
  input  logic [DATA_W-1:0] p0_wd,
  input  logic              p1_valid,
  output logic              p1_ready,
  input  logic [ADDR_W-1:0] p1_wn,
  input  logic [DATA_W-1:0] p1_wd,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rd,
  output logic              iss_ready,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic              hazard,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_wn,
  output logic [DATA_W-1:0] rf_wd,
  output logic              waw_err
);
  import cpu_pkg::*;

  localparam int CNT_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT - 1);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic [CNT_W-1:0]  r_starve_cnt;
  logic              w_p0_hs;
  logic              w_p1_hs;
  logic              w_p0_wn_busy;
  logic              r_rf_we;
  logic [ADDR_W-1:0] r_rf_wn;
  logic [DATA_W-1:0] r_rf_wd;
  logic              r_waw_err;

  // Arbiter state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= PRI0;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: PRI1 lasts only until p1 is served or withdraws.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      PRI0: begin
        if (p0_valid && p1_valid && (r_starve_cnt == CNT_MAX)) w_state_nxt = PRI1;
        else                                                   w_state_nxt = PRI0;
      end
      PRI1: begin
        if (w_p1_hs || !p1_valid) w_state_nxt = PRI0;
        else                      w_state_nxt = PRI1;
      end
      default: w_state_nxt = PRI0;
    endcase
  end

  // Grant outputs per priority state.
  always_comb begin
    p0_ready = 1'b1;
    p1_ready = 1'b0;
    case (r_state)
      PRI0: begin
        p0_ready = 1'b1;
        p1_ready = !p0_valid;
      end
      PRI1: begin
        p0_ready = !p1_valid;
        p1_ready = 1'b1;
      end
      default: begin
        p0_ready = 1'b1;
        p1_ready = !p0_valid;
      end
    endcase
  end

  assign w_p0_hs = p0_valid & p0_ready;
  assign w_p1_hs = p1_valid & p1_ready;

  // Consecutive cycles p1 has waited, saturating at the force threshold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= {CNT_W{1'b0}};
    end else if (p1_valid && !p1_ready) begin
      if (r_starve_cnt != CNT_MAX) r_starve_cnt <= r_starve_cnt + CNT_W'(1);
      else                         r_starve_cnt <= r_starve_cnt;
    end else begin
      r_starve_cnt <= {CNT_W{1'b0}};
    end
  end

  // Register-file write port register; writes to r0 are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rf_we <= 1'b0;
      r_rf_wn <= {ADDR_W{1'b0}};
      r_rf_wd <= {DATA_W{1'b0}};
    end else if (w_p1_hs) begin
      r_rf_we <= (p1_wn != {ADDR_W{1'b0}});
      r_rf_wn <= p1_wn;
      r_rf_wd <= p1_wd;
    end else if (w_p0_hs) begin
      r_rf_we <= (p0_wn != {ADDR_W{1'b0}});
      r_rf_wn <= p0_wn;
      r_rf_wd <= p0_wd;
    end else begin
      r_rf_we <= 1'b0;
    end
  end

  // Sticky flag: pipeline overwrote a register still owed by a long op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_waw_err <= 1'b0;
    end else if (w_p0_hs && w_p0_wn_busy) begin
      r_waw_err <= 1'b1;
    end else begin
      r_waw_err <= r_waw_err;
    end
  end

  assign rf_we   = r_rf_we;
  assign rf_wn   = r_rf_wn;
  assign rf_wd   = r_rf_wd;
  assign waw_err = r_waw_err;

  wb_scoreboard #(.ADDR_W(ADDR_W)) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_iss_valid (iss_valid),
    .i_iss_rd    (iss_rd),
    .o_iss_ready (iss_ready),
    .i_clr_en    (w_p1_hs),
    .i_clr_wn    (p1_wn),
    .i_rs        (rs),
    .i_rt        (rt),
    .i_chk_wn    (p0_wn),
    .o_hazard    (hazard),
    .o_chk_busy  (w_p0_wn_busy)
  );
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench: stimulus pushes expected register-file writes into a queue
// that a separate monitor drains after every clock edge.
module tb_regfile_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int SL = 4;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] wn;
    logic [DW-1:0] wd;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          p0_valid = 1'b0, p1_valid = 1'b0, iss_valid = 1'b0;
  logic [AW-1:0] p0_wn = '0, p1_wn = '0, iss_rd = '0, rs = '0, rt = '0;
  logic [DW-1:0] p0_wd = '0, p1_wd = '0;
  logic          p0_ready, p1_ready, iss_ready, hazard, rf_we, waw_err;
  logic [AW-1:0] rf_wn;
  logic [DW-1:0] rf_wd;

  wr_t  exp_q[$];
  wr_t  mon_e;
  int   n_checks = 0;
  int   n_err = 0;
  logic busy_m[32];
  int   lost_m = 0;
  logic waw_m = 1'b0;
  logic last_g1 = 1'b0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_wn(p0_wn), .p0_wd(p0_wd),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_wn(p1_wn), .p1_wd(p1_wd),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .rs(rs), .rt(rt), .hazard(hazard),
    .rf_we(rf_we), .rf_wn(rf_wn), .rf_wd(rf_wd), .waw_err(waw_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) busy_m[i] = 1'b0;
    lost_m  = 0;
    waw_m   = 1'b0;
    last_g1 = 1'b0;
    exp_q.delete();
  endtask

  // Monitor: every edge either retires one expected handshake or must be idle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("rf_we", {31'd0, rf_we}, {31'd0, mon_e.we});
          if (mon_e.we) begin
            chk("rf_wn", {27'd0, rf_wn}, {27'd0, mon_e.wn});
            chk("rf_wd", rf_wd, mon_e.wd);
          end
        end else begin
          chk("rf_we_idle", {31'd0, rf_we}, 32'd0);
        end
      end
    end
  end

  // One cycle: drive, check combinational outputs against the model, predict.
  task automatic step(input logic p0v, input logic [AW-1:0] p0wn, input logic [DW-1:0] p0wd,
                      input logic p1v, input logic [AW-1:0] p1wn, input logic [DW-1:0] p1wd,
                      input logic iv, input logic [AW-1:0] ird,
                      input logic [AW-1:0] ars, input logic [AW-1:0] art);
    logic forced, g0, g1, e_iss, e_haz;
    @(negedge clk);
    p0_valid = p0v; p0_wn = p0wn; p0_wd = p0wd;
    p1_valid = p1v; p1_wn = p1wn; p1_wd = p1wd;
    iss_valid = iss_valid; iss_valid = iv; iss_rd = ird; rs = ars; rt = art;
    #1;
    forced = (lost_m >= SL);
    if (forced) begin
      g1 = p1v;
      g0 = p0v & !p1v;
    end else begin
      g0 = p0v;
      g1 = p1v & !p0v;
    end
    e_iss = !((ird != 5'd0) && busy_m[ird]);
    e_haz = ((ars != 5'd0) && busy_m[ars]) || ((art != 5'd0) && busy_m[art]);
    chk("p0_ready", {31'd0, p0_ready}, {31'd0, forced ? !p1v : 1'b1});
    chk("p1_ready", {31'd0, p1_ready}, {31'd0, forced ? 1'b1 : !p0v});
    chk("iss_ready", {31'd0, iss_ready}, {31'd0, e_iss});
    chk("hazard", {31'd0, hazard}, {31'd0, e_haz});
    chk("waw_err", {31'd0, waw_err}, {31'd0, waw_m});
    if (g0) begin
      exp_q.push_back('{we: (p0wn != 5'd0), wn: p0wn, wd: p0wd});
      if ((p0wn != 5'd0) && busy_m[p0wn]) waw_m = 1'b1;
    end
    if (g1) begin
      exp_q.push_back('{we: (p1wn != 5'd0), wn: p1wn, wd: p1wd});
      if (p1wn != 5'd0) busy_m[p1wn] = 1'b0;
    end
    if (iv && e_iss && (ird != 5'd0)) busy_m[ird] = 1'b1;
    lost_m  = (p1v && !g1) ? lost_m + 1 : 0;
    last_g1 = g1;
  endtask

  task automatic idle(input logic [AW-1:0] ars);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, ars, 5'd0);
  endtask

  // Assert reset with every request high; outputs must show the reset state.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    p0_valid = 1'b1; p1_valid = 1'b1; iss_valid = 1'b1;
    iss_rd = 5'd9; rs = 5'd9; rt = 5'd3;
    #1;
    chk("rst_hazard", {31'd0, hazard}, 32'd0);
    chk("rst_iss_ready", {31'd0, iss_ready}, 32'd1);
    chk("rst_p1_ready", {31'd0, p1_ready}, 32'd0);
    chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rst_rf_wn", {27'd0, rf_wn}, 32'd0);
    chk("rst_rf_wd", rf_wd, 32'd0);
    chk("rst_waw_err", {31'd0, waw_err}, 32'd0);
    model_clear();
    repeat (2) @(negedge clk);
    p0_valid = 1'b0; p1_valid = 1'b0; iss_valid = 1'b0;
    rs = 5'd0; rt = 5'd0; iss_rd = 5'd0;
    rst_n = 1'b1;
  endtask

  initial begin
    logic          p1v_r;
    logic [AW-1:0] p1wn_r;
    logic [DW-1:0] p1wd_r;
    model_clear();
    do_reset();

    step(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < 5; i++)
      step(1'b1, 5'(i + 1), 32'h1000_0000 + i, 1'b1, 5'd7, 32'h7777_0007, 1'b0, 5'd0, 5'd0, 5'd0);
    step(1'b1, 5'd6, 32'h6666_0006, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);

    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd0, 5'd0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd0);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h9999_0009, 1'b0, 5'd0, 5'd9, 5'd0);
    idle(5'd9);

    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd0, 5'd3);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h3333_0001, 1'b1, 5'd3, 5'd0, 5'd3);
    idle(5'd3);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h3333_0002, 1'b1, 5'd3, 5'd0, 5'd3);
    idle(5'd3);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h3333_0003, 1'b0, 5'd0, 5'd3, 5'd0);

    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h0BAD_0000, 1'b0, 5'd0, 5'd0, 5'd0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd0, 5'd0);
    step(1'b1, 5'd9, 32'hAAAA_0009, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd0);
    idle(5'd9);
    idle(5'd9);

    for (int i = 0; i < 2; i++)
      step(1'b1, 5'd4, 32'h4444_0000 + i, 1'b1, 5'd9, 32'h9999_1111, 1'b0, 5'd0, 5'd9, 5'd0);
    do_reset();
    idle(5'd9);

    p1v_r = 1'b0; p1wn_r = '0; p1wd_r = '0;
    for (int n = 0; n < 600; n++) begin
      if (!p1v_r || last_g1) begin
        p1v_r  = ($urandom % 100) < 50;
        p1wn_r = 5'($urandom_range(0, 11));
        p1wd_r = $urandom;
      end
      step(($urandom % 100) < 60, 5'($urandom_range(0, 11)), $urandom,
           p1v_r, p1wn_r, p1wd_r,
           ($urandom % 100) < 35, 5'($urandom_range(0, 11)),
           5'($urandom_range(0, 11)), 5'($urandom_range(0, 11)));
    end
    idle(5'd0);
    idle(5'd0);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
